oddr_word_serializer: RTL

Upstream feeder for an ODDR primitive clocked from the same PLL output. It accepts parallel WIDTH-bit words over a valid/ready stream and emits two bits per clk cycle on d1/d2, which connect to the ODDR D1/D2 inputs in SAME_EDGE mode. Words in a stream are emitted back to back with no gap. When no word is pending, a fixed idle pattern is driven.

---
 rtl/oddr_word_serializer_if.sv | 14 +
 rtl/oddr_word_serializer.sv | 108 ++++++++++
 2 files changed

// File: rtl/oddr_word_serializer_if.sv
// oddr_word_serializer_if: valid/ready word stream feeding the ODDR serializer
// Signals:
//   s_data  - parallel word, WIDTH bits (master -> slave)
//   s_valid - s_data valid (master -> slave)
//   s_ready - slave can accept a word (slave -> master)
interface oddr_word_serializer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] s_data;
   logic             s_valid;
   logic             s_ready;
   modport master (output s_data, output s_valid, input s_ready);
   modport slave (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/oddr_word_serializer.sv
// oddr_word_serializer: splits WIDTH-bit words into two-bit beats for a SAME_EDGE ODDR
// Ports:
//   clk       - single clock, same net as the ODDR C input
//   rst_n     - asynchronous active-low reset
//   s         - word stream (slave modport: s_data, s_valid in; s_ready out)
//   en_i      - permits starting a new word; a word in progress always completes
//   d1_o      - bit for ODDR D1 (rising-edge half)
//   d2_o      - bit for ODDR D2 (falling-edge half)
//   frame_o   - high during beat 0 of each word
//   busy_o    - high while shifting
//   gap_cnt_o - saturating count of stream ends (shift -> idle)
module oddr_word_serializer #(
   parameter int   WIDTH     = 8,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_D1   = 1'b0,
   parameter logic IDLE_D2   = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   oddr_word_serializer_if.slave  s,
   input  logic                   en_i,
   output logic                   d1_o,
   output logic                   d2_o,
   output logic                   frame_o,
   output logic                   busy_o,
   output logic [15:0]            gap_cnt_o
);
   localparam int N = WIDTH / 2;
   localparam int BW = $clog2(N);
   localparam logic [BW-1:0] LAST = BW'(N - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] hold_q, hold_d, word_q, word_d;
   logic             hold_full_q, hold_full_d;
   logic [BW-1:0]    beat_q, beat_d;
   logic [1:0]       pair_q, pair_d;
   logic             frame_q, frame_d;
   logic [15:0]      gap_q, gap_d;
   logic             accept, load;

   // Beat k of a word: the two bits nearest the leading end after discarding k pairs
   function automatic logic [1:0] pair(input logic [WIDTH-1:0] w, input logic [BW-1:0] k);
      logic [WIDTH-1:0] t;
      t = MSB_FIRST ? w << {k, 1'b0} : w >> {k, 1'b0};
      return MSB_FIRST ? t[WIDTH-1 -: 2] : {t[0], t[1]};
   endfunction

   assign s.s_ready = !hold_full_q;
   assign accept    = s.s_valid && !hold_full_q;
   // A held word starts from idle or straight after the last beat, giving gapless streams
   assign load      = hold_full_q && en_i && (state_q == IDLE || beat_q == LAST);

   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      beat_d      = beat_q;
      pair_d      = pair_q;
      frame_d     = 1'b0;
      gap_d       = gap_q;
      hold_d      = accept ? s.s_data : hold_q;
      hold_full_d = accept ? 1'b1 : (load ? 1'b0 : hold_full_q);
      if (load) begin
         state_d = SHIFT;
         word_d  = hold_q;
         beat_d  = '0;
         pair_d  = pair(hold_q, '0);
         frame_d = 1'b1;
      end else if (state_q == SHIFT && beat_q != LAST) begin
         beat_d = beat_q + 1'b1;
         pair_d = pair(word_q, beat_q + 1'b1);
      end else if (state_q == SHIFT) begin
         state_d = IDLE;
         beat_d  = '0;
         pair_d  = {IDLE_D1, IDLE_D2};
         gap_d   = &gap_q ? gap_q : gap_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         word_q      <= '0;
         beat_q      <= '0;
         pair_q      <= {IDLE_D1, IDLE_D2};
         frame_q     <= 1'b0;
         gap_q       <= '0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         word_q      <= word_d;
         beat_q      <= beat_d;
         pair_q      <= pair_d;
         frame_q     <= frame_d;
         gap_q       <= gap_d;
      end
   end

   assign d1_o      = pair_q[1];
   assign d2_o      = pair_q[0];
   assign frame_o   = frame_q;
   assign busy_o    = state_q == SHIFT;
   assign gap_cnt_o = gap_q;
endmodule
